// File: rtl/latency_encoding_pkg.sv
// rtl/latency_encoding_pkg.sv - shared types, widths and spike-time helper for the latency encoder
package latency_encoding_pkg;

    localparam int PIX_W  = 14;
    localparam int GAIN_W = 12;
    localparam int SHIFT  = 10;
    localparam int N_PIX  = 16;
    localparam int T_W    = 4;

    localparam int PROD_W = PIX_W + GAIN_W;
    localparam int T_MAX  = (1 << T_W) - 1;
    localparam int IDX_W  = $clog2(N_PIX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIRE = 2'd2
    } state_t;

    // Scale the full-width product down and map it onto the window:
    // larger scaled values spike earlier, anything at or beyond T_MAX spikes at step 0.
    function automatic logic [T_W-1:0] spike_time(input logic [PROD_W-1:0] prod);
        logic [PROD_W-1:0] sc;
        sc = prod >> SHIFT;
        if (sc >= PROD_W'(T_MAX)) begin
            spike_time = '0;
        end else begin
            spike_time = T_W'(T_MAX) - sc[T_W-1:0];
        end
    endfunction

endpackage

// File: rtl/latency_spike_time_calc.sv
// rtl/latency_spike_time_calc.sv - combinational multiply, shift and clamp shared by all pixels
module latency_spike_time_calc
    import latency_encoding_pkg::*;
(
    input  logic [PIX_W-1:0]  pix,
    input  logic [GAIN_W-1:0] gain,
    output logic [T_W-1:0]    spk_time
);

    logic [PROD_W-1:0] prod;

    // Product is kept at full width so the clamp never sees a wrapped value.
    assign prod     = PROD_W'(pix) * PROD_W'(gain);
    assign spk_time = spike_time(prod);

endmodule

// File: rtl/latency_encoding_sched.sv
// rtl/latency_encoding_sched.sv - latency (time-to-first-spike) encoder: frame load then timestep sweep
module latency_encoding_sched
    import latency_encoding_pkg::*;
(
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [GAIN_W-1:0] gain,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [N_PIX-1:0]  spk_vec,
    output logic [T_W-1:0]    spk_step,
    output logic              spk_valid,
    input  logic              spk_ready,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_nx;
    logic [GAIN_W-1:0] gain_q;
    logic [IDX_W-1:0]  idx_q;
    logic [T_W-1:0]    t_q, t_nx;
    logic [T_W-1:0]    time_q [N_PIX];
    logic [T_W-1:0]    time_nx [N_PIX];
    logic [N_PIX-1:0]  en_q, en_nx;
    logic [N_PIX-1:0]  spk_vec_q, spk_vec_nx;
    logic [T_W-1:0]    calc_time;
    logic              pix_acc, spk_acc, last_pix, last_step;

    assign pix_acc   = (state_q == LOAD) && pix_valid;
    assign spk_acc   = (state_q == FIRE) && spk_ready;
    assign last_pix  = (idx_q == IDX_W'(N_PIX - 1));
    assign last_step = (t_q == T_W'(T_MAX));

    latency_spike_time_calc u_calc (
        .pix      (pix_data),
        .gain     (gain_q),
        .spk_time (calc_time)
    );

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state logic: start only counts in IDLE, last pixel enters FIRE, last step returns to IDLE
    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (pix_acc && last_pix) state_nx = FIRE;
            FIRE:    if (spk_acc && last_step) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from the current state; done coincides with the final handshake
    always_comb begin
        pix_ready = (state_q == LOAD);
        spk_valid = (state_q == FIRE);
        busy      = (state_q != IDLE);
        done      = spk_acc && last_step;
        spk_step  = t_q;
        spk_vec   = spk_vec_q;
    end

    // Next buffer contents and next spike vector, built from the post-write buffer so the
    // first vector is ready in the cycle right after the last pixel lands
    always_comb begin
        time_nx = time_q;
        en_nx   = en_q;
        if (pix_acc) begin
            time_nx[idx_q] = calc_time;
            en_nx[idx_q]   = |pix_data;
        end
        t_nx = spk_acc ? t_q + T_W'(1) : t_q;
        for (int i = 0; i < N_PIX; i++) begin
            spk_vec_nx[i] = (state_nx == FIRE) && en_nx[i] && (time_nx[i] == t_nx);
        end
    end

    // Control and enable registers
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            gain_q    <= '0;
            idx_q     <= '0;
            t_q       <= '0;
            en_q      <= '0;
            spk_vec_q <= '0;
        end else begin
            if ((state_q == IDLE) && start) begin
                gain_q <= gain;
            end
            if (pix_acc) begin
                idx_q <= last_pix ? '0 : idx_q + IDX_W'(1);
            end
            t_q       <= t_nx;
            en_q      <= en_nx;
            spk_vec_q <= spk_vec_nx;
        end
    end

    // Spike-time buffer; entries are only meaningful where the matching enable bit is set
    always_ff @(posedge ap_clk) begin
        time_q <= time_nx;
    end

endmodule

// File: tb/tb_latency_encoding_sched.sv
// tb/tb_latency_encoding_sched.sv - scoreboard bench for latency_encoding_sched
module tb_latency_encoding_sched;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] gain = '0;
    logic [13:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [15:0] spk_vec;
    logic [3:0]  spk_step;
    logic        spk_valid;
    logic        spk_ready = 1'b0;
    logic        busy;
    logic        done;

    latency_encoding_sched dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .start     (start),
        .gain      (gain),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .spk_vec   (spk_vec),
        .spk_step  (spk_step),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [3:0]  step;
        logic [15:0] vec;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_vec = 0;
    logic mon_en = 1'b0;
    int   px[16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic int exp_time(input int p, input int g);
        int sc;
        sc = (p * g) >>> 10;
        return (sc >= 15) ? 0 : 15 - sc;
    endfunction

    // Every accepted spike vector is compared against the next scoreboard entry
    always @(negedge ap_clk) begin
        if (mon_en && spk_valid && spk_ready) begin
            if (sb.size() == 0) begin
                check("spk_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("spk_step", 32'(spk_step), 32'(mon_e.step));
                check("spk_vec", 32'(spk_vec), 32'(mon_e.vec));
                check("done", 32'(done), 32'(mon_e.last));
                n_vec++;
            end
        end else if (mon_en && done) begin
            check("done_stray", 32'(done), 32'd0);
        end
    end

    task automatic run_frame(input int g, input int pix[16], input bit gaps,
                             input int bp_step, input int rst_step);
        int          tt[16];
        logic [15:0] vecs[16];
        exp_t        e;
        int          cyc;
        int          stall;
        bit          fin;

        for (int i = 0; i < 16; i++) tt[i] = exp_time(pix[i], g);
        for (int t = 0; t < 16; t++) begin
            vecs[t] = '0;
            for (int i = 0; i < 16; i++)
                if (pix[i] != 0 && tt[i] == t) vecs[t][i] = 1'b1;
        end
        for (int t = 0; t < 16; t++) begin
            if (rst_step < 0 || t < rst_step) begin
                e.step = 4'(t);
                e.vec  = vecs[t];
                e.last = (t == 15);
                sb.push_back(e);
            end
        end
        n_vec = 0;

        start = 1'b1;
        gain  = 12'(g);
        step();
        start = 1'b0;
        gain  = 12'($urandom_range(0, 4095));

        for (int i = 0; i < 16; i++) begin
            pix_valid = 1'b1;
            pix_data  = 14'(pix[i]);
            if (i == 3) begin
                start = 1'b1;
                gain  = 12'hFFF;
            end
            @(negedge ap_clk);
            check("pix_ready", 32'(pix_ready), 32'd1);
            check("no_fire_early", 32'(spk_valid), 32'd0);
            step();
            start = 1'b0;
            if (gaps && i < 15) begin
                pix_valid = 1'b0;
                pix_data  = 14'h3FFF;
                step();
            end
        end
        pix_valid = 1'b0;
        @(negedge ap_clk);
        check("fire_latency", 32'(spk_valid), 32'd1);
        check("pix_ready_fire", 32'(pix_ready), 32'd0);
        step();

        cyc   = 0;
        stall = 0;
        fin   = 1'b0;
        while (!fin && cyc < 200) begin
            if (rst_step >= 0 && int'(spk_step) == rst_step) begin
                spk_ready = 1'b0;
                ap_rst_n  = 1'b0;
                step();
                ap_rst_n = 1'b1;
                @(negedge ap_clk);
                check("rst_spk_valid", 32'(spk_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_spk_step", 32'(spk_step), 32'd0);
                check("rst_spk_vec", 32'(spk_vec), 32'd0);
                check("rst_vec_count", 32'(n_vec), 32'(rst_step));
                check("rst_sb_drained", 32'(sb.size()), 32'd0);
                sb.delete();
                step();
                return;
            end
            if (bp_step >= 0 && int'(spk_step) == bp_step && stall < 5) begin
                spk_ready = 1'b0;
                stall++;
                @(negedge ap_clk);
                check("bp_step", 32'(spk_step), 32'(bp_step));
                check("bp_vec", 32'(spk_vec), 32'(vecs[bp_step]));
                check("bp_valid", 32'(spk_valid), 32'd1);
            end else begin
                spk_ready = 1'b1;
                if (spk_step == 4'd15) start = 1'b1;
                @(negedge ap_clk);
                if (done) fin = 1'b1;
            end
            step();
            start = 1'b0;
            cyc++;
        end
        spk_ready = 1'b0;
        if (!fin) check("frame_timeout", 32'd0, 32'd1);
        @(negedge ap_clk);
        check("start_at_done_ignored", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("spk_valid_idle", 32'(spk_valid), 32'd0);
        check("vec_count", 32'(n_vec), 32'd16);
        check("sb_drained", 32'(sb.size()), 32'd0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        check("reset_pix_ready", 32'(pix_ready), 32'd0);
        check("reset_spk_valid", 32'(spk_valid), 32'd0);
        check("reset_spk_vec", 32'(spk_vec), 32'd0);
        check("reset_spk_step", 32'(spk_step), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        step();
        ap_rst_n = 1'b1;
        mon_en   = 1'b1;
        step();

        // basic frame with input gaps, stray start in LOAD and backpressure at step 7
        for (int i = 0; i < 16; i++) px[i] = int'($urandom_range(0, 16383));
        px[0] = 5120; px[1] = 1024; px[2] = 0; px[3] = 7168;
        run_frame(2, px, 1'b1, 7, -1);

        // saturation at maximum gain
        for (int i = 0; i < 16; i++) px[i] = int'($urandom_range(0, 16383));
        px[0] = 16383; px[1] = 0; px[2] = 1;
        run_frame(4095, px, 1'b0, -1, -1);

        // unit gain around the clamp boundary
        for (int i = 0; i < 16; i++) px[i] = int'($urandom_range(0, 16383));
        px[0] = 15360; px[1] = 14336; px[2] = 1023; px[3] = 0;
        run_frame(1, px, 1'b0, 3, -1);

        // zero gain: every nonzero pixel fires at the last step
        for (int i = 0; i < 16; i++) px[i] = int'($urandom_range(0, 16383));
        px[0] = 100; px[1] = 0;
        run_frame(0, px, 1'b0, -1, -1);

        // reset during FIRE at step 9
        for (int i = 0; i < 16; i++) px[i] = int'($urandom_range(0, 16383));
        run_frame(5, px, 1'b0, -1, 9);

        // recovery frame after the mid-frame reset
        for (int i = 0; i < 16; i++) px[i] = int'($urandom_range(0, 16383));
        px[5] = 0;
        run_frame(3, px, 1'b1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
